// File: rtl/sram_scan_ctrl.sv
// Scan-driven SRAM test sequencer: shifts a command packet in, issues one
// dual-port access to the selected macro, captures read data, shifts it out.
module sram_scan_ctrl #(
   parameter int unsigned NUM_SRAM = 4,
   parameter int unsigned SEL_W    = 4,
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned WMASK_W  = 4,
   parameter int unsigned READ_LAT = 1
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_i,
   input  logic                         scan_en,
   input  logic                         scan_in,
   input  logic                         load,
   output logic                         scan_out,
   output logic                         busy,
   output logic                         sel_err,
   output logic [NUM_SRAM-1:0]          csb0_o,
   output logic                         web0_o,
   output logic [WMASK_W-1:0]           wmask0_o,
   output logic [ADDR_W-1:0]            addr0_o,
   output logic [DATA_W-1:0]            din0_o,
   input  logic [NUM_SRAM*DATA_W-1:0]   dout0_i,
   output logic [NUM_SRAM-1:0]          csb1_o,
   output logic                         web1_o,
   output logic [WMASK_W-1:0]           wmask1_o,
   output logic [ADDR_W-1:0]            addr1_o,
   output logic [DATA_W-1:0]            din1_o,
   input  logic [NUM_SRAM*DATA_W-1:0]   dout1_i
);

   localparam int unsigned PORT_W   = ADDR_W + DATA_W + 2 + WMASK_W;
   localparam int unsigned PKT_W    = SEL_W + 2 * PORT_W;
   localparam int unsigned WEB_OFS  = WMASK_W;
   localparam int unsigned CSB_OFS  = WMASK_W + 1;
   localparam int unsigned DIN_OFS  = WMASK_W + 2;
   localparam int unsigned ADDR_OFS = WMASK_W + 2 + DATA_W;
   localparam int unsigned P0_LSB   = PORT_W;
   localparam int unsigned P1_LSB   = 0;
   localparam int unsigned WAIT_CYC = READ_LAT - 1;
   localparam int unsigned CNT_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;

   state_t               state, state_nxt;
   logic [PKT_W-1:0]     shift_reg;
   logic                 load_q;
   logic [CNT_W-1:0]     wait_cnt;

   logic [SEL_W-1:0]     sel;
   logic                 sel_ok;
   logic [PORT_W-1:0]    port_bits [2];
   logic [NUM_SRAM*DATA_W-1:0] port_dout [2];
   logic [1:0]           p_csb, p_web, rd_en;
   logic [WMASK_W-1:0]   p_wmask [2];
   logic [ADDR_W-1:0]    p_addr  [2];
   logic [DATA_W-1:0]    p_din   [2];
   logic [DATA_W-1:0]    p_rd    [2];

   assign sel          = shift_reg[PKT_W-1 -: SEL_W];
   assign sel_ok       = 32'(sel) < NUM_SRAM;
   assign port_bits[0] = shift_reg[P0_LSB +: PORT_W];
   assign port_bits[1] = shift_reg[P1_LSB +: PORT_W];
   assign port_dout[0] = dout0_i;
   assign port_dout[1] = dout1_i;
   assign scan_out     = shift_reg[PKT_W-1];

   // Field decode and read-data select; an out-of-range sel selects zero data
   always_comb begin
      for (int unsigned p = 0; p < 2; p++) begin
         p_wmask[p] = port_bits[p][0 +: WMASK_W];
         p_web[p]   = port_bits[p][WEB_OFS];
         p_csb[p]   = port_bits[p][CSB_OFS];
         p_din[p]   = port_bits[p][DIN_OFS +: DATA_W];
         p_addr[p]  = port_bits[p][ADDR_OFS +: ADDR_W];
         rd_en[p]   = ~port_bits[p][CSB_OFS] & port_bits[p][WEB_OFS];
         p_rd[p]    = '0;
         for (int unsigned k = 0; k < NUM_SRAM; k++) begin
            if (32'(sel) == k) p_rd[p] = port_dout[p][k*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      sel_err   = 1'b0;
      csb0_o    = '1;
      csb1_o    = '1;
      web0_o    = 1'b1;
      web1_o    = 1'b1;
      wmask0_o  = '0;
      wmask1_o  = '0;
      addr0_o   = '0;
      addr1_o   = '0;
      din0_o    = '0;
      din1_o    = '0;
      case (state)
         S_IDLE: begin
            if (!scan_en && load && !load_q) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            busy     = 1'b1;
            web0_o   = p_web[0];
            web1_o   = p_web[1];
            wmask0_o = p_wmask[0];
            wmask1_o = p_wmask[1];
            addr0_o  = p_addr[0];
            addr1_o  = p_addr[1];
            din0_o   = p_din[0];
            din1_o   = p_din[1];
            for (int unsigned k = 0; k < NUM_SRAM; k++) begin
               if (32'(sel) == k) begin
                  csb0_o[k] = p_csb[0];
                  csb1_o[k] = p_csb[1];
               end
            end
            state_nxt = (WAIT_CYC == 0) ? S_CAPTURE : S_WAIT;
         end
         S_WAIT: begin
            busy = 1'b1;
            if (wait_cnt == WAIT_LAST) state_nxt = S_CAPTURE;
         end
         S_CAPTURE: begin
            busy      = 1'b1;
            sel_err   = ~sel_ok;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= S_IDLE;
         shift_reg <= '0;
         load_q    <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         state  <= state_nxt;
         load_q <= load;
         case (state)
            S_IDLE: begin
               if (scan_en) shift_reg <= {shift_reg[PKT_W-2:0], scan_in};
            end
            S_ISSUE: wait_cnt <= '0;
            S_WAIT:  wait_cnt <= wait_cnt + CNT_W'(1);
            S_CAPTURE: begin
               if (rd_en[0]) shift_reg[P0_LSB+DIN_OFS +: DATA_W] <= p_rd[0];
               if (rd_en[1]) shift_reg[P1_LSB+DIN_OFS +: DATA_W] <= p_rd[1];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_scan_ctrl.sv
// Scoreboard bench for sram_scan_ctrl: transaction-level reference model,
// behavioural SRAM macros on the port buses, decoupled bus/scan monitors.
module tb_sram_scan_ctrl;

   localparam int NS = 4;
   localparam int RL = 2;
   localparam int PKT_W = 112;

   typedef struct packed {
      logic [15:0] addr;
      logic [31:0] din;
      logic        csb;
      logic        web;
      logic [3:0]  wmask;
   } port_t;

   typedef struct packed {
      logic [3:0] sel;
      port_t      p0;
      port_t      p1;
   } pkt_t;

   typedef struct packed {
      logic [3:0]  csb0;
      logic        web0;
      logic [3:0]  wmask0;
      logic [15:0] addr0;
      logic [31:0] din0;
      logic [3:0]  csb1;
      logic        web1;
      logic [3:0]  wmask1;
      logic [15:0] addr1;
      logic [31:0] din1;
   } bus_t;

   typedef struct {
      bus_t bus;
      int   len;
      bit   err;
   } acc_t;

   logic          wb_clk_i = 1'b0;
   logic          wb_rst_i, scan_en, scan_in, load;
   logic          scan_out, busy, sel_err;
   logic [3:0]    csb0_o, csb1_o, wmask0_o, wmask1_o;
   logic          web0_o, web1_o;
   logic [15:0]   addr0_o, addr1_o;
   logic [31:0]   din0_o, din1_o;
   logic [127:0]  dout0_i, dout1_i;

   sram_scan_ctrl #(
      .NUM_SRAM(NS), .SEL_W(4), .ADDR_W(16), .DATA_W(32), .WMASK_W(4), .READ_LAT(RL)
   ) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .scan_en(scan_en), .scan_in(scan_in),
      .load(load), .scan_out(scan_out), .busy(busy), .sel_err(sel_err),
      .csb0_o(csb0_o), .web0_o(web0_o), .wmask0_o(wmask0_o), .addr0_o(addr0_o),
      .din0_o(din0_o), .dout0_i(dout0_i),
      .csb1_o(csb1_o), .web1_o(web1_o), .wmask1_o(wmask1_o), .addr1_o(addr1_o),
      .din1_o(din1_o), .dout1_i(dout1_i)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   function automatic logic [31:0] byte_mask(input logic [3:0] m);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[b*8 +: 8] = {8{m[b]}};
      return r;
   endfunction

   // Behavioural SRAM macros: READ_LAT-deep read pipeline, read-old-data
   logic        env_init;
   logic [31:0] env_mem [NS][16];
   logic [31:0] pipe0   [NS][RL];
   logic [31:0] pipe1   [NS][RL];

   always @(posedge wb_clk_i) begin
      for (int k = 0; k < NS; k++) begin
         if (env_init) begin
            for (int a = 0; a < 16; a++) env_mem[k][a] <= '0;
            for (int s = 0; s < RL; s++) begin
               pipe0[k][s] <= '0;
               pipe1[k][s] <= '0;
            end
         end else begin
            if (!csb0_o[k] && web0_o) pipe0[k][0] <= env_mem[k][addr0_o[3:0]];
            if (!csb1_o[k] && web1_o) pipe1[k][0] <= env_mem[k][addr1_o[3:0]];
            for (int s = 1; s < RL; s++) begin
               pipe0[k][s] <= pipe0[k][s-1];
               pipe1[k][s] <= pipe1[k][s-1];
            end
            if (!csb0_o[k] && !web0_o)
               env_mem[k][addr0_o[3:0]] <= (env_mem[k][addr0_o[3:0]] & ~byte_mask(wmask0_o))
                                           | (din0_o & byte_mask(wmask0_o));
            if (!csb1_o[k] && !web1_o)
               env_mem[k][addr1_o[3:0]] <= (env_mem[k][addr1_o[3:0]] & ~byte_mask(wmask1_o))
                                           | (din1_o & byte_mask(wmask1_o));
         end
      end
   end

   always_comb begin
      dout0_i = '0;
      dout1_i = '0;
      for (int k = 0; k < NS; k++) begin
         dout0_i[k*32 +: 32] = pipe0[k][RL-1];
         dout1_i[k*32 +: 32] = pipe1[k][RL-1];
      end
   end

   // Reference model: whole access as one transaction on packet fields
   logic [31:0] ref_mem [NS][16];
   pkt_t        cur;
   acc_t        acc_q[$];
   pkt_t        pkt_q[$];
   bit          done = 1'b0;

   function automatic bus_t idle_bus();
      bus_t b = '0;
      b.csb0 = '1; b.csb1 = '1; b.web0 = 1'b1; b.web1 = 1'b1;
      return b;
   endfunction

   task automatic ref_access(input pkt_t p, output acc_t a, output pkt_t np);
      bit valid;
      valid = int'(p.sel) < NS;
      np = p;
      a.bus = '0;
      a.bus.csb0 = '1;
      a.bus.csb1 = '1;
      if (valid && !p.p0.csb) a.bus.csb0[p.sel[1:0]] = 1'b0;
      if (valid && !p.p1.csb) a.bus.csb1[p.sel[1:0]] = 1'b0;
      a.bus.web0 = p.p0.web;  a.bus.wmask0 = p.p0.wmask;
      a.bus.addr0 = p.p0.addr; a.bus.din0 = p.p0.din;
      a.bus.web1 = p.p1.web;  a.bus.wmask1 = p.p1.wmask;
      a.bus.addr1 = p.p1.addr; a.bus.din1 = p.p1.din;
      a.len = RL + 1;
      a.err = !valid;
      if (!p.p0.csb && p.p0.web) np.p0.din = valid ? ref_mem[p.sel[1:0]][p.p0.addr[3:0]] : 32'd0;
      if (!p.p1.csb && p.p1.web) np.p1.din = valid ? ref_mem[p.sel[1:0]][p.p1.addr[3:0]] : 32'd0;
      if (valid && !p.p0.csb && !p.p0.web)
         ref_mem[p.sel[1:0]][p.p0.addr[3:0]] = (ref_mem[p.sel[1:0]][p.p0.addr[3:0]] & ~byte_mask(p.p0.wmask))
                                               | (p.p0.din & byte_mask(p.p0.wmask));
      if (valid && !p.p1.csb && !p.p1.web)
         ref_mem[p.sel[1:0]][p.p1.addr[3:0]] = (ref_mem[p.sel[1:0]][p.p1.addr[3:0]] & ~byte_mask(p.p1.wmask))
                                               | (p.p1.din & byte_mask(p.p1.wmask));
   endtask

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic shift_frame(input pkt_t p, input pkt_t exp_out, input bit with_load);
      pkt_q.push_back(exp_out);
      for (int i = PKT_W - 1; i >= 0; i--) begin
         scan_en = 1'b1;
         scan_in = p[i];
         if (with_load && i == PKT_W - 1) load = 1'b1;
         tick();
      end
      scan_en = 1'b0;
      cur = p;
   endtask

   task automatic do_access();
      acc_t a;
      pkt_t np;
      ref_access(cur, a, np);
      acc_q.push_back(a);
      cur = np;
      load = 1'b1;
      tick();
      load = 1'b0;
      repeat (RL + 2) tick();
   endtask

   function automatic port_t mk_port(input logic [15:0] addr, input logic [31:0] din,
                                     input logic csb, input logic web, input logic [3:0] wm);
      port_t q;
      q.addr = addr; q.din = din; q.csb = csb; q.web = web; q.wmask = wm;
      return q;
   endfunction

   function automatic pkt_t rand_pkt();
      pkt_t p;
      p.sel = 4'($urandom_range(0, 5));
      p.p0 = mk_port(16'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) == 0,
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      p.p1 = mk_port(16'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) == 0,
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      if (!p.p0.csb && !p.p0.web && !p.p1.csb && !p.p1.web && p.p0.addr == p.p1.addr)
         p.p1.csb = 1'b1;
      return p;
   endfunction

   // Stimulus
   initial begin
      pkt_t wp, mp, rp, ip, e;
      acc_t a;
      pkt_t np;
      wb_rst_i = 1'b1; scan_en = 1'b0; scan_in = 1'b0; load = 1'b0; env_init = 1'b1;
      for (int k = 0; k < NS; k++)
         for (int j = 0; j < 16; j++) ref_mem[k][j] = '0;
      cur = '0;
      tick();
      env_init = 1'b0;
      tick();
      wb_rst_i = 1'b0;
      tick();

      wp = '0; wp.sel = 4'd1;
      wp.p0 = mk_port(16'd1, 32'd1, 1'b0, 1'b0, 4'hF);
      wp.p1 = mk_port(16'd0, 32'd0, 1'b1, 1'b0, 4'h0);
      shift_frame(wp, cur, 1'b0);
      do_access();

      mp = '0; mp.sel = 4'd2;
      mp.p0 = mk_port(16'd1, 32'd1, 1'b0, 1'b0, 4'hF);
      mp.p1 = mk_port(16'd2, 32'd2, 1'b0, 1'b0, 4'hF);
      shift_frame(mp, cur, 1'b0);
      do_access();

      rp = '0; rp.sel = 4'd2;
      rp.p0 = mk_port(16'd1, 32'd0, 1'b0, 1'b1, 4'h0);
      rp.p1 = mk_port(16'd2, 32'd0, 1'b0, 1'b1, 4'h0);
      shift_frame(rp, cur, 1'b0);
      do_access();

      e = '0; e.sel = 4'd2;
      e.p0 = mk_port(16'd1, 32'd1, 1'b0, 1'b1, 4'h0);
      e.p1 = mk_port(16'd2, 32'd2, 1'b0, 1'b1, 4'h0);
      ip = '0; ip.sel = 4'd7;
      ip.p0 = mk_port(16'd3, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'h0);
      ip.p1 = mk_port(16'd4, 32'h1234_5678, 1'b0, 1'b1, 4'h0);
      shift_frame(ip, e, 1'b0);
      do_access();

      // load edge coincident with shifting, then held high: no access
      shift_frame(rp, cur, 1'b1);
      repeat (5) tick();
      load = 1'b0;
      tick();
      do_access();

      for (int n = 0; n < 40; n++) begin
         shift_frame(rand_pkt(), cur, 1'b0);
         do_access();
         repeat ($urandom_range(0, 3)) tick();
      end

      // reset while in WAIT aborts the access
      shift_frame(rp, cur, 1'b0);
      ref_access(cur, a, np);
      a.len = 2;
      a.err = 1'b0;
      acc_q.push_back(a);
      load = 1'b1;
      tick();
      load = 1'b0;
      tick();
      wb_rst_i = 1'b1;
      tick();
      wb_rst_i = 1'b0;
      cur = '0;
      repeat (3) tick();

      shift_frame(rand_pkt(), cur, 1'b0);
      tick();
      done = 1'b1;
   end

   // Monitor / scoreboard
   int          n_tests = 0;
   int          n_fail  = 0;
   bit          prev_busy = 1'b0;
   bit          prev_rst  = 1'b0;
   int          cyc = 0;
   acc_t        cur_acc;
   logic [111:0] frame = '0;
   int          nbits = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge wb_clk_i) begin
      bus_t obs;
      pkt_t ep;
      obs = {csb0_o, web0_o, wmask0_o, addr0_o, din0_o, csb1_o, web1_o, wmask1_o, addr1_o, din1_o};
      if (prev_rst)
         chk("reset_state", {obs, busy, sel_err, scan_out}, {idle_bus(), 3'b000});
      if (busy && !prev_busy) begin
         if (acc_q.size() == 0) begin
            chk("unexpected_access", 128'd1, 128'd0);
            cur_acc.bus = idle_bus();
            cur_acc.len = -1;
            cur_acc.err = 1'b0;
         end else begin
            cur_acc = acc_q.pop_front();
            chk("issue_bus", 128'(obs), 128'(cur_acc.bus));
         end
         cyc = 1;
         chk("sel_err", 128'(sel_err), 128'((cyc == cur_acc.len) && cur_acc.err));
      end else if (busy) begin
         cyc++;
         chk("wait_bus", 128'(obs), 128'(idle_bus()));
         chk("sel_err", 128'(sel_err), 128'((cyc == cur_acc.len) && cur_acc.err));
      end else begin
         if (prev_busy) chk("busy_len", 128'(cyc), 128'(cur_acc.len));
         chk("idle_bus", {obs, sel_err}, {idle_bus(), 1'b0});
      end
      if (scan_en && !busy && !wb_rst_i) begin
         frame = {frame[110:0], scan_out};
         nbits++;
         if (nbits == PKT_W) begin
            nbits = 0;
            if (pkt_q.size() == 0) chk("unexpected_frame", 128'd1, 128'd0);
            else begin
               ep = pkt_q.pop_front();
               chk("scan_frame", 128'(frame), 128'(ep));
            end
         end
      end
      prev_busy = busy;
      prev_rst  = wb_rst_i;
      if (done) begin
         chk("acc_q_drained", 128'(acc_q.size()), 128'd0);
         chk("pkt_q_drained", 128'(pkt_q.size()), 128'd0);
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
         $finish;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
